// File: rtl/ofs_asp_pkg.sv
// Shared constants for the shim_avst streaming blocks.
package ofs_asp_pkg;
  localparam int SHIM_AVST_DATA_WIDTH = 32;
endpackage

// File: rtl/shim_avst_buffer.sv
// Registered shim_avst FIFO buffer with fill level, almost-full flag and
// high-watermark tracking. Both handshake outputs come from registered state only.
module shim_avst_buffer #(
  parameter int DATA_WIDTH            = ofs_asp_pkg::SHIM_AVST_DATA_WIDTH,
  parameter int DEPTH                 = 16,
  parameter int ALMOST_FULL_THRESHOLD = 12
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         snk_valid,
  output logic                         snk_ready,
  input  logic [DATA_WIDTH-1:0]        snk_data,
  output logic                         src_valid,
  input  logic                         src_ready,
  output logic [DATA_WIDTH-1:0]        src_data,
  output logic [$clog2(DEPTH+1)-1:0]   fill_level,
  output logic                         almost_full,
  output logic [$clog2(DEPTH+1)-1:0]   high_watermark
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]      r_wrPtr;
  logic [PTR_W-1:0]      r_rdPtr;
  logic [CNT_W-1:0]      r_fillLevel;
  logic [CNT_W-1:0]      r_highWatermark;

  logic                  w_push;
  logic                  w_pop;
  logic [CNT_W-1:0]      w_fillNext;

  // Handshakes depend only on the fill register, so no valid/ready feedthrough.
  assign snk_ready      = (r_fillLevel != CNT_W'(DEPTH));
  assign src_valid      = (r_fillLevel != '0);
  assign src_data       = r_mem[r_rdPtr];
  assign fill_level     = r_fillLevel;
  assign almost_full    = (r_fillLevel >= CNT_W'(ALMOST_FULL_THRESHOLD));
  assign high_watermark = r_highWatermark;

  assign w_push = snk_valid && snk_ready;
  assign w_pop  = src_valid && src_ready;

  always_comb begin
    w_fillNext = r_fillLevel;
    if (w_push && !w_pop) begin
      w_fillNext = r_fillLevel + CNT_W'(1);
    end else if (!w_push && w_pop) begin
      w_fillNext = r_fillLevel - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wrPtr         <= '0;
      r_rdPtr         <= '0;
      r_fillLevel     <= '0;
      r_highWatermark <= '0;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + PTR_W'(1);
      end
      r_fillLevel <= w_fillNext;
      if (w_fillNext > r_highWatermark) begin
        r_highWatermark <= w_fillNext;
      end
    end
  end

  // Payload storage carries no reset; stale entries are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (w_push && !reset) begin
      r_mem[r_wrPtr] <= snk_data;
    end
  end

endmodule
